uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares one UART transmitter (ready/send/data byte interface) between N_REQ byte requesters using a round-robin scheme. Multi-byte packets are supported: once a requester is granted, it keeps the grant until it sends a byte marked last. The block sequences the UART handshake by issuing a single-cycle send, waiting for ready to fall, then waiting for ready to rise again. It sits between debug/telemetry sources (switch capture, game-state dumps) and the board TX pin driver.

Parameters:
N_REQ, 4, number of requesters; legal range 2..16.
LOW_TIMEOUT, 8, cycles to wait for uart_ready to fall after a send before assuming the UART accepted the byte.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst  input  1  asynchronous active-high reset.
req_valid  input  N_REQ  per-requester byte available.
req_last  input  N_REQ  the offered byte ends that requester's packet.
req_data  input  8*N_REQ  requester i byte on bits [8i+7:8i].
req_ack  output  N_REQ  one-cycle pulse: byte consumed; the requester advances on this pulse.
uart_ready  input  1  UART idle/ready.
uart_send  output  1  one-cycle start pulse to the UART.
uart_data  output  8  byte to the UART; stable from the send pulse until the return to IDLE.
grant_id  output  4  current or last granted requester.
locked  output  1  a packet is in progress (the grant is held).
busy  output  1  state is not IDLE.

Behaviour:
- Reset (asynchronous): state=IDLE; req_ack=0; uart_send=0; uart_data=0; grant_id=N_REQ-1; locked=0; busy=0; rr pointer=N_REQ-1; timeout counter=0.
- All outputs are registered.
- States: IDLE, WAIT_LOW, WAIT_HIGH (plus TAG_NEXT, see Optional Feature).
- Pick rule (IDLE): pick only when uart_ready=1.
  - If locked: the only candidate is grant_id; wait indefinitely for its req_valid.
  - If not locked: the winner is the first set req_valid scanning from pointer+1 upward, modulo N_REQ.
- On a pick (at the edge): uart_data<=winner byte; uart_send<=1; req_ack[winner]<=1; grant_id<=winner; pointer<=winner; locked<=~req_last[winner]; state<=WAIT_LOW.
  - uart_send and req_ack are high for exactly the next cycle.
- Pick latency: 1 cycle from an IDLE cycle with ready=1 and valid=1 to the send pulse.
- WAIT_LOW:
  - uart_ready=0 -> WAIT_HIGH.
  - Otherwise count; at LOW_TIMEOUT cycles -> WAIT_HIGH (the UART deasserted and reasserted ready within the same cycle, or was too fast to observe).
- WAIT_HIGH: uart_ready=1 -> IDLE.
- Minimum spacing between sends: 4 cycles plus the UART frame time.
- Simultaneous requests: exactly one ack per pick; the others hold valid.
- Wrap-around: after granting N_REQ-1, the scan starts again at 0.
- A requester deasserting valid mid-packet (while locked) stalls all requesters. This is by design: packets are never interleaved.
- req_valid with uart_ready=0 in IDLE: no pick, no ack.
- Reset mid-frame: the controller returns to IDLE immediately. A UART frame already started completes under the UART's own control; the interrupted packet is not resumed (locked=0).
- req_data and req_last are sampled only on the pick edge.

Optional Feature:
Macro UART_ARB_TAG_EN.
- Defined: each packet's first byte is preceded by a tag byte 8'hA0|grant_id[3:0].
  - A pick with locked=0 sends the tag first: uart_data=tag, no req_ack, and the data byte is latched internally.
  - After WAIT_HIGH, state=TAG_NEXT; when uart_ready=1, the latched byte is sent and req_ack pulses at that point.
  - Subsequent bytes of the same packet are untagged.
- Undefined: no tag byte, and the TAG_NEXT state does not exist.

Decomposition:
- Package uart_arb_pkg:
  - state enum type;
  - TAG_BASE=8'hA0;
  - GRANT_W=4;
  - function rr_next (pointer, valid vector -> index plus found flag).
- Sub-module rr_pick: purely combinational rotate-priority picker, parameterised by N_REQ; instanced once.

Test Plan:
- Single requester: rst, valid[0]=1, data=8'h55, last=1, ready=1 -> uart_send pulses 1 cycle later; uart_data=8'h55; req_ack[0] pulses; UART model drops ready 1 cycle later, raises it 10 cycles later -> IDLE; busy=0.
- Contention: valid=4'b1111, all last=1, bytes 8'h10..8'h13 held -> send order 8'h10, 11, 12, 13, 10 (wrap); exactly one ack per send.
- Packet lock: req1 sends 3 bytes with last only on the third, while req0 and req2 stay valid -> the three req1 bytes go out consecutively, then req2, then req0.
- Stall/timeout: UART model never drops ready -> WAIT_HIGH entered after LOW_TIMEOUT=8 cycles; the next byte is sent normally.
- Reset mid-operation: rst pulsed during WAIT_HIGH with locked=1 -> all outputs return to reset values asynchronously; after release, req2 is granted first (pointer=N_REQ-1).
- With UART_ARB_TAG_EN: req3 sends 8'h7E with last=1 -> UART sees 8'hA3 then 8'h7E; req_ack[3] pulses only at the second send.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
// UART_ARB_TAG_EN adds the TAG_NEXT state used for per-packet tag bytes.
package uart_arb_pkg;

    localparam int GRANT_W = 4;
    localparam int MAX_REQ = 16;
    localparam logic [7:0] TAG_BASE = 8'hA0;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_LOW  = 2'd1,
        ST_WAIT_HIGH = 2'd2
`ifdef UART_ARB_TAG_EN
        , ST_TAG_NEXT = 2'd3
`endif
    } state_t;

    typedef struct packed {
        logic               found;
        logic [GRANT_W-1:0] idx;
    } rr_result_t;

    // First set bit of valid scanning upward from ptr+1, wrapping modulo n.
    // The last slot visited is ptr itself, so a lone requester is re-granted.
    function automatic rr_result_t rr_next(input logic [GRANT_W-1:0] ptr,
                                           input logic [MAX_REQ-1:0] valid,
                                           input int n);
        rr_result_t res;
        logic [GRANT_W:0] idx;
        res = '0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            if (k <= n && !res.found) begin
                idx = (GRANT_W+1)'(ptr) + (GRANT_W+1)'(k);
                if (idx >= (GRANT_W+1)'(n)) begin
                    idx = idx - (GRANT_W+1)'(n);
                end
                if (valid[idx[GRANT_W-1:0]]) begin
                    res.found = 1'b1;
                    res.idx   = idx[GRANT_W-1:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational rotate-priority picker: finds the next valid requester
// after the round-robin pointer.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [GRANT_W-1:0] pointer,
    input  logic [N_REQ-1:0]   valid,
    output logic               found,
    output logic [GRANT_W-1:0] idx
);

    logic [MAX_REQ-1:0] valid_ext;
    rr_result_t         res;

    // Widen the request vector to the helper's fixed width and scan it.
    always_comb begin
        valid_ext              = '0;
        valid_ext[N_REQ-1:0]   = valid;
        res                    = rr_next(pointer, valid_ext, N_REQ);
    end

    assign found = res.found;
    assign idx   = res.idx;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte
// sources. A granted requester keeps the grant until it sends a byte
// marked last. Optional macro UART_ARB_TAG_EN prefixes each packet with
// a tag byte TAG_BASE | grant_id.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int LOW_TIMEOUT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ-1:0]     req_last,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     req_ack,
    input  logic                 uart_ready,
    output logic                 uart_send,
    output logic [7:0]           uart_data,
    output logic [GRANT_W-1:0]   grant_id,
    output logic                 locked,
    output logic                 busy
);

    localparam int CNT_W = $clog2(LOW_TIMEOUT + 1);

    state_t               state_reg, state_next;
    logic [N_REQ-1:0]     req_ack_reg, req_ack_next;
    logic                 uart_send_reg, uart_send_next;
    logic [7:0]           uart_data_reg, uart_data_next;
    logic [GRANT_W-1:0]   grant_reg, grant_next;
    logic [GRANT_W-1:0]   ptr_reg, ptr_next;
    logic                 locked_reg, locked_next;
    logic                 busy_reg, busy_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
`ifdef UART_ARB_TAG_EN
    logic [7:0]           hold_data_reg, hold_data_next;
    logic                 hold_last_reg, hold_last_next;
    logic                 tag_pending_reg, tag_pending_next;
`endif

    logic [MAX_REQ-1:0]   valid_ext;
    logic [MAX_REQ-1:0]   last_ext;
    logic [7:0]           data_arr [MAX_REQ];
    logic [N_REQ-1:0]     ack_hit;
    logic                 pick_found;
    logic [GRANT_W-1:0]   pick_idx;
    logic                 take;
    logic [GRANT_W-1:0]   win;

    // Spread requester lanes onto fixed-size tables so a 4-bit grant can
    // index them directly; unused lanes read as idle.
    generate
        for (genvar gi = 0; gi < MAX_REQ; gi++) begin : g_lane
            if (gi < N_REQ) begin : g_used
                assign valid_ext[gi] = req_valid[gi];
                assign last_ext[gi]  = req_last[gi];
                assign data_arr[gi]  = req_data[8*gi +: 8];
            end else begin : g_pad
                assign valid_ext[gi] = 1'b0;
                assign last_ext[gi]  = 1'b0;
                assign data_arr[gi]  = 8'h00;
            end
        end
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ack
            assign ack_hit[gi] = (win == GRANT_W'(gi));
        end
    endgenerate

    rr_pick #(
        .N_REQ   (N_REQ)
    ) u_rr_pick (
        .pointer (ptr_reg),
        .valid   (req_valid),
        .found   (pick_found),
        .idx     (pick_idx)
    );

    // Choose this cycle's winner: a held packet pins the grant, otherwise
    // the round-robin picker decides. Nothing is taken while the UART is busy.
    always_comb begin
        take = 1'b0;
        win  = grant_reg;
        if (state_reg == ST_IDLE && uart_ready) begin
            if (locked_reg) begin
                take = valid_ext[grant_reg];
            end else begin
                win  = pick_idx;
                take = pick_found;
            end
        end
    end

    // Next-state logic for the send / wait-low / wait-high handshake.
    always_comb begin
        state_next     = state_reg;
        req_ack_next   = '0;
        uart_send_next = 1'b0;
        uart_data_next = uart_data_reg;
        grant_next     = grant_reg;
        ptr_next       = ptr_reg;
        locked_next    = locked_reg;
        cnt_next       = cnt_reg;
`ifdef UART_ARB_TAG_EN
        hold_data_next   = hold_data_reg;
        hold_last_next   = hold_last_reg;
        tag_pending_next = tag_pending_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (take) begin
                    grant_next     = win;
                    ptr_next       = win;
                    uart_send_next = 1'b1;
                    cnt_next       = '0;
                    state_next     = ST_WAIT_LOW;
`ifdef UART_ARB_TAG_EN
                    if (!locked_reg) begin
                        // New packet: send the tag now, park the data byte.
                        uart_data_next   = TAG_BASE | {{(8-GRANT_W){1'b0}}, win};
                        hold_data_next   = data_arr[win];
                        hold_last_next   = last_ext[win];
                        tag_pending_next = 1'b1;
                        locked_next      = 1'b1;
                    end else begin
                        uart_data_next = data_arr[win];
                        req_ack_next   = ack_hit;
                        locked_next    = ~last_ext[win];
                    end
`else
                    uart_data_next = data_arr[win];
                    req_ack_next   = ack_hit;
                    locked_next    = ~last_ext[win];
`endif
                end
            end
            ST_WAIT_LOW: begin
                // A UART that never shows ready low is assumed to have taken
                // the byte once the timeout expires.
                if (!uart_ready) begin
                    state_next = ST_WAIT_HIGH;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_W'(LOW_TIMEOUT - 1)) begin
                    state_next = ST_WAIT_HIGH;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_WAIT_HIGH: begin
                if (uart_ready) begin
`ifdef UART_ARB_TAG_EN
                    state_next = tag_pending_reg ? ST_TAG_NEXT : ST_IDLE;
`else
                    state_next = ST_IDLE;
`endif
                end
            end
`ifdef UART_ARB_TAG_EN
            ST_TAG_NEXT: begin
                // Release the parked data byte; the requester is acked only now.
                if (uart_ready) begin
                    uart_send_next   = 1'b1;
                    uart_data_next   = hold_data_reg;
                    req_ack_next     = ack_hit;
                    locked_next      = ~hold_last_reg;
                    tag_pending_next = 1'b0;
                    cnt_next         = '0;
                    state_next       = ST_WAIT_LOW;
                end
            end
`endif
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        busy_next = (state_next != ST_IDLE);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            req_ack_reg   <= '0;
            uart_send_reg <= 1'b0;
            uart_data_reg <= 8'h00;
            grant_reg     <= GRANT_W'(N_REQ - 1);
            ptr_reg       <= GRANT_W'(N_REQ - 1);
            locked_reg    <= 1'b0;
            busy_reg      <= 1'b0;
            cnt_reg       <= '0;
`ifdef UART_ARB_TAG_EN
            hold_data_reg   <= 8'h00;
            hold_last_reg   <= 1'b0;
            tag_pending_reg <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            req_ack_reg   <= req_ack_next;
            uart_send_reg <= uart_send_next;
            uart_data_reg <= uart_data_next;
            grant_reg     <= grant_next;
            ptr_reg       <= ptr_next;
            locked_reg    <= locked_next;
            busy_reg      <= busy_next;
            cnt_reg       <= cnt_next;
`ifdef UART_ARB_TAG_EN
            hold_data_reg   <= hold_data_next;
            hold_last_reg   <= hold_last_next;
            tag_pending_reg <= tag_pending_next;
`endif
        end
    end

    assign req_ack   = req_ack_reg;
    assign uart_send = uart_send_reg;
    assign uart_data = uart_data_reg;
    assign grant_id  = grant_reg;
    assign locked    = locked_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester queues and a UART model
// run on the falling edge; each send pulse pops one expected entry.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int N_REQ       = 4;
    localparam int LOW_TIMEOUT = 8;
`ifdef UART_ARB_TAG_EN
    localparam bit TAG_EN = 1'b1;
`else
    localparam bit TAG_EN = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ-1:0]     req_last;
    logic [8*N_REQ-1:0]   req_data;
    logic [N_REQ-1:0]     req_ack;
    logic                 uart_ready;
    logic                 uart_send;
    logic [7:0]           uart_data;
    logic [3:0]           grant_id;
    logic                 locked;
    logic                 busy;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ       (N_REQ),
        .LOW_TIMEOUT (LOW_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_last    (req_last),
        .req_data    (req_data),
        .req_ack     (req_ack),
        .uart_ready  (uart_ready),
        .uart_send   (uart_send),
        .uart_data   (uart_data),
        .grant_id    (grant_id),
        .locked      (locked),
        .busy        (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Expected UART traffic
    typedef struct {
        logic [7:0] data;
        logic [3:0] ack;
        logic [3:0] grant;
        logic       lock;
    } exp_t;
    exp_t sb[$];
    int   exp_sends = 0;

    task automatic sb_push(input int idx, input logic [7:0] d, input logic last, input logic first);
        exp_t e;
        if (first && TAG_EN) begin
            e.data  = 8'hA0 | 8'(idx);
            e.ack   = 4'b0000;
            e.grant = 4'(idx);
            e.lock  = 1'b1;
            sb.push_back(e);
            exp_sends++;
        end
        e.data  = d;
        e.ack   = 4'(1 << idx);
        e.grant = 4'(idx);
        e.lock  = ~last;
        sb.push_back(e);
        exp_sends++;
    endtask

    // Per-requester byte queues
    logic [7:0] q_data [N_REQ][8];
    logic       q_last [N_REQ][8];
    int         q_head [N_REQ];
    int         q_tail [N_REQ];

    task automatic load(input int idx, input logic [7:0] d, input logic last);
        q_data[idx][q_tail[idx]] = d;
        q_last[idx][q_tail[idx]] = last;
        q_tail[idx]++;
    endtask

    int cyc = 0;
    int send_cnt = 0;
    int send_log [64];
    int vrise_cyc [N_REQ];
    int ready_hold = 0;
    int busy_run = 0;
    int last_busy_len = 0;
    bit drop_en = 1'b1;
    bit hold_low = 1'b0;

    // Falling-edge loop: monitor, requester models, UART model
    initial begin
        exp_t e;
        req_valid  = '0;
        req_last   = '0;
        req_data   = '0;
        uart_ready = 1'b1;
        for (int i = 0; i < N_REQ; i++) begin
            q_head[i] = 0;
            q_tail[i] = 0;
            vrise_cyc[i] = 0;
        end
        forever begin
            @(negedge clk);
            if (uart_send) begin
                if (send_cnt < 64) send_log[send_cnt] = cyc;
                send_cnt++;
                check("sb_has_entry", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    $display("[TB] send #%0d data=%02h ack=%b grant=%0d locked=%b", send_cnt, uart_data, req_ack, grant_id, locked);
                    check("send_data", uart_data, e.data);
                    check("send_ack", req_ack, e.ack);
                    check("send_grant", grant_id, e.grant);
                    check("send_locked", locked, e.lock);
                end
            end
            if (busy) begin
                busy_run++;
            end else if (busy_run != 0) begin
                last_busy_len = busy_run;
                busy_run = 0;
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (req_ack[i] && q_head[i] < q_tail[i]) q_head[i]++;
                if (q_head[i] < q_tail[i]) begin
                    if (!req_valid[i]) vrise_cyc[i] = cyc;
                    req_valid[i]       = 1'b1;
                    req_last[i]        = q_last[i][q_head[i]];
                    req_data[8*i +: 8] = q_data[i][q_head[i]];
                end else begin
                    req_valid[i]       = 1'b0;
                    req_last[i]        = 1'b0;
                    req_data[8*i +: 8] = 8'h00;
                end
            end
            if (uart_send && drop_en) begin
                ready_hold = 10;
            end else if (ready_hold > 0) begin
                ready_hold--;
            end
            uart_ready = !(hold_low || ready_hold > 0);
            cyc++;
        end
    end

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy || !uart_ready) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n < 400), 1);
        repeat (2) @(negedge clk);
        check({tag, "_count"}, send_cnt, exp_sends);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_ack"}, req_ack, 0);
        check({pfx, "_send"}, uart_send, 0);
        check({pfx, "_data"}, uart_data, 0);
        check({pfx, "_grant"}, grant_id, N_REQ - 1);
        check({pfx, "_locked"}, locked, 0);
        check({pfx, "_busy"}, busy, 0);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int base;
        int n;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset");
        @(posedge clk); #1 rst = 1'b0;

        // Single requester and pick latency
        base = send_cnt;
        load(0, 8'h55, 1'b1);
        sb_push(0, 8'h55, 1'b1, 1'b1);
        wait_drain("single_drain");
        check("single_latency", send_log[base] - vrise_cyc[0], 1);
        check("single_grant", grant_id, 0);
        check("single_locked", locked, 0);

        // Contention from a fresh pointer, including wrap-around
        pulse_reset();
        @(posedge clk); #1;
        load(0, 8'h10, 1'b1); load(0, 8'h10, 1'b1);
        load(1, 8'h11, 1'b1); load(2, 8'h12, 1'b1); load(3, 8'h13, 1'b1);
        sb_push(0, 8'h10, 1'b1, 1'b1);
        sb_push(1, 8'h11, 1'b1, 1'b1);
        sb_push(2, 8'h12, 1'b1, 1'b1);
        sb_push(3, 8'h13, 1'b1, 1'b1);
        sb_push(0, 8'h10, 1'b1, 1'b1);
        wait_drain("contend_drain");

        // Packet lock: req1 sends three bytes uninterrupted
        @(posedge clk); #1;
        load(1, 8'hA1, 1'b0); load(1, 8'hA2, 1'b0); load(1, 8'hA3, 1'b1);
        load(0, 8'h20, 1'b1); load(2, 8'h30, 1'b1);
        sb_push(1, 8'hA1, 1'b0, 1'b1);
        sb_push(1, 8'hA2, 1'b0, 1'b0);
        sb_push(1, 8'hA3, 1'b1, 1'b0);
        sb_push(2, 8'h30, 1'b1, 1'b1);
        sb_push(0, 8'h20, 1'b1, 1'b1);
        wait_drain("lock_drain");

        // No pick while the UART reports not ready
        @(posedge clk); #1 hold_low = 1'b1;
        repeat (2) @(posedge clk); #1;
        base = send_cnt;
        load(1, 8'h99, 1'b1);
        repeat (6) @(negedge clk);
        check("ready_low_no_send", send_cnt, base);
        check("ready_low_no_ack", req_ack, 0);
        sb_push(1, 8'h99, 1'b1, 1'b1);
        @(posedge clk); #1 hold_low = 1'b0;
        wait_drain("ready_low_drain");

        // Timeout: UART never drops ready
        @(posedge clk); #1 drop_en = 1'b0;
        load(3, 8'h77, 1'b1);
        sb_push(3, 8'h77, 1'b1, 1'b1);
        wait_drain("timeout_drain");
        check("timeout_busy_len", last_busy_len,
              TAG_EN ? 2 * (LOW_TIMEOUT + 1) + 1 : LOW_TIMEOUT + 1);
        @(posedge clk); #1 drop_en = 1'b1;
        load(0, 8'h88, 1'b1);
        sb_push(0, 8'h88, 1'b1, 1'b1);
        wait_drain("after_timeout_drain");

        // Reset during WAIT_HIGH with a packet locked
        @(posedge clk); #1;
        load(1, 8'hB1, 1'b0); load(1, 8'hB2, 1'b1);
        load(2, 8'hC1, 1'b1); load(3, 8'hD1, 1'b1);
        sb_push(1, 8'hB1, 1'b0, 1'b1);
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("midrst_first_send", 32'(n < 400), 1);
        repeat (3) @(negedge clk);
        check("midrst_locked_before", locked, 1);
        check("midrst_busy_before", busy, 1);
        @(posedge clk); #2;
        rst = 1'b1;
        q_head[1] = q_tail[1];
        #1 check_reset_outputs("midrst");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sb_push(2, 8'hC1, 1'b1, 1'b1);
        sb_push(3, 8'hD1, 1'b1, 1'b1);
        wait_drain("midrst_drain");

        // Single-byte packet from req3 (tagged when the feature is built in)
        @(posedge clk); #1;
        load(3, 8'h7E, 1'b1);
        sb_push(3, 8'h7E, 1'b1, 1'b1);
        wait_drain("req3_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
